// File: rtl/iir_pkg.sv
// Shared filter package for the IIR stage and its downstream blocks.
// Holds the default sample format (width / fractional bits), the sample
// typedef and the defaults of the decimating output buffer.
package iir_pkg;

  localparam int unsigned IIR_NB_DATA  = 16;  // sample width, signed Q1.15
  localparam int unsigned IIR_NBF_DATA = 15;  // fractional bits of the sample

  localparam int unsigned IIR_NB_DECIM   = 4;  // width of decimation factor
  localparam int unsigned IIR_FIFO_DEPTH = 8;  // output buffer depth (words)

  typedef logic signed [IIR_NB_DATA-1:0] sample_t;

endpackage : iir_pkg

// File: rtl/sync_fifo.sv
// Synchronous first-word-fall-through FIFO built from a register array.
// Ports:
//   clk_i    - clock, rising edge
//   rst_i    - synchronous active-high reset (pointers/level cleared)
//   push_i   - write request; accepted when not full, or when full with a
//              simultaneous accepted pop
//   pop_i    - read request; ignored while empty
//   wdata_i  - write data
//   rdata_o  - head-of-queue word (zero while empty)
//   level_o  - occupancy, 0..DEPTH
//   full_o   - level == DEPTH
//   empty_o  - level == 0
module sync_fifo #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 8,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic [AW:0]      level_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      level_q,  level_d;
  logic             wr_en, rd_en;

  assign full_o  = (level_q == (AW+1)'(DEPTH));
  assign empty_o = (level_q == '0);
  assign level_o = level_q;

  assign rd_en = pop_i  & ~empty_o;
  // When full, a write is only possible because the head leaves this cycle.
  assign wr_en = push_i & (~full_o | rd_en);

  assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

  // DEPTH is a power of two, so pointer wrap is the natural overflow.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_en) rd_ptr_d = rd_ptr_q + 1'b1;
    unique case ({wr_en, rd_en})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage needs no reset: reads are masked while the FIFO is empty.
  always_ff @(posedge clk_i) begin
    if (!rst_i && wr_en) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule : sync_fifo

// File: rtl/iir_decim_fifo.sv
// Decimator plus output buffer behind the IIR stage. Keeps one of every M
// enabled samples (M latched from i_decim at each period start, 0 -> 1) and
// queues the kept samples in a FWFT FIFO for a ready-driven consumer.
// Ports:
//   clock      - sole clock, rising edge
//   i_reset    - synchronous active-high reset, highest priority
//   i_data     - signed filtered sample, valid while i_enable=1
//   i_enable   - sample strobe shared with the IIR
//   i_decim    - decimation factor M
//   i_ready    - consumer takes o_data this cycle
//   i_clr_ovf  - clears o_overflow (a same-cycle drop wins)
//   o_data     - oldest unread sample
//   o_valid    - o_data valid (o_level > 0)
//   o_level    - buffer occupancy
//   o_overflow - sticky: a kept sample was dropped because the buffer was full
module iir_decim_fifo
  import iir_pkg::*;
#(
  parameter int unsigned NB_DATA    = IIR_NB_DATA,
  parameter int unsigned NBF_DATA   = IIR_NBF_DATA,
  parameter int unsigned NB_DECIM   = IIR_NB_DECIM,
  parameter int unsigned FIFO_DEPTH = IIR_FIFO_DEPTH
) (
  input  logic                          clock,
  input  logic                          i_reset,
  input  logic signed [NB_DATA-1:0]     i_data,
  input  logic                          i_enable,
  input  logic [NB_DECIM-1:0]           i_decim,
  input  logic                          i_ready,
  input  logic                          i_clr_ovf,
  output logic signed [NB_DATA-1:0]     o_data,
  output logic                          o_valid,
  output logic [$clog2(FIFO_DEPTH):0]   o_level,
  output logic                          o_overflow
);

  // Sample format sanity: the fraction is carried through, never altered.
  if (NBF_DATA >= NB_DATA) begin : g_bad_frac
    $error("NBF_DATA must be smaller than NB_DATA");
  end
  if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of two, at least 2");
  end

  localparam logic [NB_DECIM-1:0] ONE = {{(NB_DECIM-1){1'b0}}, 1'b1};

  logic [NB_DECIM-1:0] phase_q, phase_d;
  logic [NB_DECIM-1:0] m_q, m_d;
  logic [NB_DECIM-1:0] decim_eff;
  logic                ovf_q, ovf_d;
  logic                keep, pop, drop;
  logic                fifo_full, fifo_empty;
  logic [NB_DATA-1:0]  fifo_rdata;

  assign decim_eff = (i_decim == '0) ? ONE : i_decim;
  assign keep      = i_enable & (phase_q == '0);

  // The new factor is latched on the keep cycle and already governs the
  // phase step taken on that same edge, so M=1 stays at phase 0.
  always_comb begin
    phase_d = phase_q;
    m_d     = m_q;
    if (i_enable) begin
      if (phase_q == '0) begin
        m_d     = decim_eff;
        phase_d = (decim_eff == ONE) ? '0 : ONE;
      end else begin
        phase_d = (phase_q == m_q - ONE) ? '0 : phase_q + ONE;
      end
    end
  end

  assign pop   = o_valid & i_ready;
  assign drop  = keep & fifo_full & ~pop;
  assign ovf_d = drop | (ovf_q & ~i_clr_ovf);

  always_ff @(posedge clock) begin
    if (i_reset) begin
      phase_q <= '0;
      m_q     <= decim_eff;
      ovf_q   <= 1'b0;
    end else begin
      phase_q <= phase_d;
      m_q     <= m_d;
      ovf_q   <= ovf_d;
    end
  end

  sync_fifo #(
    .WIDTH (NB_DATA),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clock),
    .rst_i   (i_reset),
    .push_i  (keep),
    .pop_i   (pop),
    .wdata_i (i_data),
    .rdata_o (fifo_rdata),
    .level_o (o_level),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign o_data     = fifo_rdata;
  assign o_valid    = ~fifo_empty;
  assign o_overflow = ovf_q;

endmodule : iir_decim_fifo

// File: tb/tb_iir_decim_fifo.sv
module tb_iir_decim_fifo;

  logic               clock = 1'b0;
  logic               i_reset = 1'b0;
  logic signed [15:0] i_data = '0;
  logic               i_enable = 1'b0;
  logic [3:0]         i_decim = '0;
  logic               i_ready = 1'b0;
  logic               i_clr_ovf = 1'b0;
  logic signed [15:0] o_data;
  logic               o_valid;
  logic [3:0]         o_level;
  logic               o_overflow;

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;

  iir_decim_fifo #(
    .NB_DATA    (16),
    .NBF_DATA   (15),
    .NB_DECIM   (4),
    .FIFO_DEPTH (8)
  ) dut (
    .clock      (clock),
    .i_reset    (i_reset),
    .i_data     (i_data),
    .i_enable   (i_enable),
    .i_decim    (i_decim),
    .i_ready    (i_ready),
    .i_clr_ovf  (i_clr_ovf),
    .o_data     (o_data),
    .o_valid    (o_valid),
    .o_level    (o_level),
    .o_overflow (o_overflow)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Advance one edge; outputs are sampled 1 ns after it.
  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset(input logic [3:0] decim);
    i_reset   = 1'b1;
    i_decim   = decim;
    i_enable  = 1'b0;
    i_ready   = 1'b0;
    i_clr_ovf = 1'b0;
    tick();
    i_reset   = 1'b0;
  endtask

  task automatic push(input int v);
    i_data   = 16'(v);
    i_enable = 1'b1;
    tick();
    i_enable = 1'b0;
  endtask

  // Pop n words, checking each head value against first, first+1, ...
  task automatic drain(input string tag, input int first, input int n);
    i_enable = 1'b0;
    i_ready  = 1'b1;
    for (int j = 0; j < n; j++) begin
      chk({tag, "_valid"}, 32'(o_valid), 32'd1);
      chk({tag, "_data"},  32'(o_data), 32'(first + j));
      tick();
    end
    i_ready = 1'b0;
    chk({tag, "_empty"}, 32'(o_level), 32'd0);
  endtask

  // Kept positions for the factor-change run: 1,4,6,8 of samples 1..9.
  logic exp_keep41 [1:9] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

  initial begin
    // Reset state, M=4 ramp
    do_reset(4'd4);
    chk("rst_valid", 32'(o_valid),    32'd0);
    chk("rst_level", 32'(o_level),    32'd0);
    chk("rst_data",  32'(o_data),     32'd0);
    chk("rst_ovf",   32'(o_overflow), 32'd0);
    i_ready  = 1'b1;
    i_enable = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      i_data = 16'(k);
      tick();
      // kept samples 1,5,9,13 show up right after their edge, then get popped
      chk("m4_valid", 32'(o_valid), (k % 4 == 1) ? 32'd1 : 32'd0);
      if (k % 4 == 1) chk("m4_data", 32'(o_data), 32'(k));
    end
    i_enable = 1'b0;

    // Factor 0 behaves as 1
    do_reset(4'd0);
    i_ready  = 1'b1;
    i_enable = 1'b1;
    for (int k = 100; k <= 102; k++) begin
      i_data = 16'(k);
      tick();
      chk("m0_valid", 32'(o_valid), 32'd1);
      chk("m0_data",  32'(o_data),  32'(k));
      chk("m0_ovf",   32'(o_overflow), 32'd0);
    end
    i_enable = 1'b0;

    // Full: 9 samples into depth 8, no reads
    do_reset(4'd1);
    for (int k = 1; k <= 8; k++) push(k);
    chk("full_level8", 32'(o_level),    32'd8);
    chk("full_ovf8",   32'(o_overflow), 32'd0);
    push(9);
    chk("full_level9", 32'(o_level),    32'd8);
    chk("full_ovf9",   32'(o_overflow), 32'd1);
    chk("full_head",   32'(o_data),     32'd1);
    drain("full_drain", 1, 8);
    chk("ovf_sticky",  32'(o_overflow), 32'd1);
    i_clr_ovf = 1'b1;
    tick();
    i_clr_ovf = 1'b0;
    chk("ovf_clr",     32'(o_overflow), 32'd0);

    // Full with simultaneous pop
    do_reset(4'd1);
    for (int k = 1; k <= 8; k++) push(k);
    i_data   = 16'd9;
    i_enable = 1'b1;
    i_ready  = 1'b1;
    tick();
    i_enable = 1'b0;
    i_ready  = 1'b0;
    chk("fpop_level", 32'(o_level),    32'd8);
    chk("fpop_ovf",   32'(o_overflow), 32'd0);
    chk("fpop_head",  32'(o_data),     32'd2);
    // drop together with a clear: set wins
    i_data    = 16'd10;
    i_enable  = 1'b1;
    i_clr_ovf = 1'b1;
    tick();
    i_enable  = 1'b0;
    i_clr_ovf = 1'b0;
    chk("setwins_ovf", 32'(o_overflow), 32'd1);
    drain("fpop_drain", 2, 8);

    // Factor change 3 -> 2 at phase 1
    do_reset(4'd3);
    i_ready  = 1'b1;
    i_enable = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      i_data = 16'(k);
      tick();
      if (k == 1) i_decim = 4'd2;
      chk("mchg_valid", 32'(o_valid), 32'(exp_keep41[k]));
      if (exp_keep41[k]) chk("mchg_data", 32'(o_data), 32'(k));
    end
    i_enable = 1'b0;
    i_ready  = 1'b0;

    // Reset mid-run with level 5 and overflow set
    do_reset(4'd1);
    for (int k = 1; k <= 9; k++) push(k);
    i_ready = 1'b1;
    tick(); tick(); tick();
    i_ready = 1'b0;
    chk("mid_level5", 32'(o_level),    32'd5);
    chk("mid_ovf",    32'(o_overflow), 32'd1);
    i_reset   = 1'b1;
    i_enable  = 1'b1;
    i_data    = 16'd77;
    i_ready   = 1'b1;
    i_clr_ovf = 1'b0;
    tick();
    i_reset  = 1'b0;
    i_enable = 1'b0;
    i_ready  = 1'b0;
    chk("mid_rst_valid", 32'(o_valid),    32'd0);
    chk("mid_rst_level", 32'(o_level),    32'd0);
    chk("mid_rst_ovf",   32'(o_overflow), 32'd0);
    push(50);
    chk("mid_first_valid", 32'(o_valid), 32'd1);
    chk("mid_first_data",  32'(o_data),  32'd50);
    chk("mid_first_level", 32'(o_level), 32'd1);
    // ready on empty is ignored
    drain("mid_drain", 50, 1);
    i_ready = 1'b1;
    tick();
    i_ready = 1'b0;
    chk("empty_pop_level", 32'(o_level), 32'd0);
    chk("empty_pop_valid", 32'(o_valid), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule : tb_iir_decim_fifo
